// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: instruction fetch and data load/store share one memory port.
// Data wins ties, bounded by a streak counter so instruction fetch is never starved.
module mem_arbiter #(
  parameter int WIDTH          = 64,
  parameter int MAX_DATA_BURST = 4
) (
  input  logic             p_clk,
  input  logic             p_rst,
  // instruction port
  input  logic [WIDTH-1:0] p_INST_MemAddress,
  input  logic             p_INST_MemRead,
  output logic [31:0]      p_INST_MemDataIn,
  output logic             p_INST_MemWait,
  // data port
  input  logic [WIDTH-1:0] p_DATA_MemAddress,
  input  logic [WIDTH-1:0] p_DATA_MemDataOut,
  input  logic             p_DATA_MemRead,
  input  logic [3:0]       p_DATA_MemWrite,
  output logic [WIDTH-1:0] p_DATA_MemDataIn,
  output logic             p_DATA_MemWait,
  // memory port
  output logic [WIDTH-1:0] p_MEM_Address,
  output logic [WIDTH-1:0] p_MEM_WriteData,
  output logic             p_MEM_Read,
  output logic [3:0]       p_MEM_Write,
  input  logic [WIDTH-1:0] p_MEM_ReadData,
  input  logic             p_MEM_Ready,
  output logic [1:0]       p_ARB_Grant
);

  localparam int              SW         = $clog2(MAX_DATA_BURST + 1);
  localparam logic [SW-1:0]   MAX_STREAK = SW'(MAX_DATA_BURST);

  // Encoding doubles as the grant code.
  typedef enum logic [1:0] {
    S_IDLE     = 2'b00,
    S_INST_ACC = 2'b01,
    S_DATA_ACC = 2'b10
  } state_t;

  state_t           r_state, w_next_state;
  logic [WIDTH-1:0] r_mem_addr, w_next_addr;
  logic [WIDTH-1:0] r_mem_wdata, w_next_wdata;
  logic             r_mem_read, w_next_read;
  logic [3:0]       r_mem_write, w_next_write;
  logic [SW-1:0]    r_streak, w_next_streak;

  logic w_inst_req;
  logic w_data_req;
  logic w_streak_full;
  logic w_data_wins;

  assign w_inst_req    = p_INST_MemRead;
  assign w_data_req    = p_DATA_MemRead || (p_DATA_MemWrite != 4'b0000);
  assign w_streak_full = (r_streak == MAX_STREAK);
  assign w_data_wins   = w_data_req && !(w_inst_req && w_streak_full);

  // NOTE: every signal gets its hold value first so no path through the case leaves it unassigned (no latches).
  always_comb begin
    w_next_state  = r_state;
    w_next_addr   = r_mem_addr;
    w_next_wdata  = r_mem_wdata;
    w_next_read   = r_mem_read;
    w_next_write  = r_mem_write;
    w_next_streak = r_streak;

    case (r_state)
      S_IDLE: begin
        if (!w_inst_req) begin
          w_next_streak = '0;
        end

        if (w_data_wins) begin
          w_next_state = S_DATA_ACC;
          w_next_addr  = p_DATA_MemAddress;
          w_next_wdata = p_DATA_MemDataOut;
          // A store beats a simultaneous load strobe.
          if (p_DATA_MemWrite != 4'b0000) begin
            w_next_read  = 1'b0;
            w_next_write = p_DATA_MemWrite;
          end else begin
            w_next_read  = 1'b1;
            w_next_write = 4'b0000;
          end
          if (w_inst_req && !w_streak_full) begin
            w_next_streak = r_streak + 1'b1;
          end
        end else if (w_inst_req) begin
          w_next_state  = S_INST_ACC;
          w_next_addr   = p_INST_MemAddress;
          w_next_read   = 1'b1;
          w_next_write  = 4'b0000;
          w_next_streak = '0;
        end
      end

      S_INST_ACC, S_DATA_ACC: begin
        if (p_MEM_Ready) begin
          w_next_state = S_IDLE;
          w_next_read  = 1'b0;
          w_next_write = 4'b0000;
        end
      end

      default: begin
        w_next_state = S_IDLE;
        w_next_read  = 1'b0;
        w_next_write = 4'b0000;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge p_clk) begin
    if (p_rst) begin
      r_state     <= S_IDLE;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 4'b0000;
      r_streak    <= '0;
    end else begin
      r_state     <= w_next_state;
      r_mem_addr  <= w_next_addr;
      r_mem_wdata <= w_next_wdata;
      r_mem_read  <= w_next_read;
      r_mem_write <= w_next_write;
      r_streak    <= w_next_streak;
    end
  end

  assign p_MEM_Address    = r_mem_addr;
  assign p_MEM_WriteData  = r_mem_wdata;
  assign p_MEM_Read       = r_mem_read;
  assign p_MEM_Write      = r_mem_write;
  assign p_ARB_Grant      = r_state;

  // Wait drops in the same cycle Ready completes the owning access.
  assign p_INST_MemWait   = w_inst_req && !((r_state == S_INST_ACC) && p_MEM_Ready);
  assign p_DATA_MemWait   = w_data_req && !((r_state == S_DATA_ACC) && p_MEM_Ready);
  assign p_INST_MemDataIn = p_MEM_ReadData[31:0];
  assign p_DATA_MemDataIn = p_MEM_ReadData;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic,
// compared every cycle against a transaction-level reference model.
module tb_mem_arbiter;
  localparam int W    = 64;
  localparam int MAXB = 4;

  logic          p_clk = 1'b0;
  logic          p_rst;
  logic [W-1:0]  p_INST_MemAddress;
  logic          p_INST_MemRead;
  logic [31:0]   p_INST_MemDataIn;
  logic          p_INST_MemWait;
  logic [W-1:0]  p_DATA_MemAddress;
  logic [W-1:0]  p_DATA_MemDataOut;
  logic          p_DATA_MemRead;
  logic [3:0]    p_DATA_MemWrite;
  logic [W-1:0]  p_DATA_MemDataIn;
  logic          p_DATA_MemWait;
  logic [W-1:0]  p_MEM_Address;
  logic [W-1:0]  p_MEM_WriteData;
  logic          p_MEM_Read;
  logic [3:0]    p_MEM_Write;
  logic [W-1:0]  p_MEM_ReadData;
  logic          p_MEM_Ready;
  logic [1:0]    p_ARB_Grant;

  always #5 p_clk = ~p_clk;

  mem_arbiter #(.WIDTH(W), .MAX_DATA_BURST(MAXB)) dut (
    .p_clk(p_clk), .p_rst(p_rst),
    .p_INST_MemAddress(p_INST_MemAddress), .p_INST_MemRead(p_INST_MemRead),
    .p_INST_MemDataIn(p_INST_MemDataIn), .p_INST_MemWait(p_INST_MemWait),
    .p_DATA_MemAddress(p_DATA_MemAddress), .p_DATA_MemDataOut(p_DATA_MemDataOut),
    .p_DATA_MemRead(p_DATA_MemRead), .p_DATA_MemWrite(p_DATA_MemWrite),
    .p_DATA_MemDataIn(p_DATA_MemDataIn), .p_DATA_MemWait(p_DATA_MemWait),
    .p_MEM_Address(p_MEM_Address), .p_MEM_WriteData(p_MEM_WriteData),
    .p_MEM_Read(p_MEM_Read), .p_MEM_Write(p_MEM_Write),
    .p_MEM_ReadData(p_MEM_ReadData), .p_MEM_Ready(p_MEM_Ready),
    .p_ARB_Grant(p_ARB_Grant)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: who owns the memory, the access it latched, and the data streak.
  int           m_owner;   // 0 none, 1 instruction, 2 data
  logic [W-1:0] m_addr;
  logic [W-1:0] m_wdata;
  logic         m_read;
  logic [3:0]   m_write;
  int           m_streak;

  function automatic bit inst_pending();
    return p_INST_MemRead;
  endfunction

  function automatic bit data_pending();
    return p_DATA_MemRead || (p_DATA_MemWrite != 4'b0000);
  endfunction

  task automatic model_update();
    bit ir;
    bit dr;
    bit data_wins;
    ir = inst_pending();
    dr = data_pending();
    if (p_rst) begin
      m_owner = 0; m_addr = '0; m_wdata = '0; m_read = 1'b0; m_write = 4'b0000; m_streak = 0;
    end else if (m_owner == 0) begin
      data_wins = dr && !(ir && m_streak == MAXB);
      if (!ir)            m_streak = 0;
      else if (data_wins) m_streak = (m_streak < MAXB) ? m_streak + 1 : MAXB;
      else                m_streak = 0;
      if (data_wins) begin
        m_owner = 2;
        m_addr  = p_DATA_MemAddress;
        m_wdata = p_DATA_MemDataOut;
        if (p_DATA_MemWrite != 4'b0000) begin
          m_read = 1'b0; m_write = p_DATA_MemWrite;
        end else begin
          m_read = 1'b1; m_write = 4'b0000;
        end
      end else if (ir) begin
        m_owner = 1;
        m_addr  = p_INST_MemAddress;
        m_read  = 1'b1;
        m_write = 4'b0000;
      end
    end else if (p_MEM_Ready) begin
      m_owner = 0; m_read = 1'b0; m_write = 4'b0000;
    end
  endtask

  task automatic check_outputs();
    bit exp_iw;
    bit exp_dw;
    exp_iw = inst_pending() && !(m_owner == 1 && p_MEM_Ready);
    exp_dw = data_pending() && !(m_owner == 2 && p_MEM_Ready);
    check("grant",     W'(p_ARB_Grant),      W'(m_owner));
    check("mem_addr",  p_MEM_Address,        m_addr);
    check("mem_wdata", p_MEM_WriteData,      m_wdata);
    check("mem_read",  W'(p_MEM_Read),       W'(m_read));
    check("mem_write", W'(p_MEM_Write),      W'(m_write));
    check("inst_wait", W'(p_INST_MemWait),   W'(exp_iw));
    check("data_wait", W'(p_DATA_MemWait),   W'(exp_dw));
    check("inst_rdata", W'(p_INST_MemDataIn), W'(p_MEM_ReadData[31:0]));
    check("data_rdata", p_DATA_MemDataIn,    p_MEM_ReadData);
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 time unit later.
  task automatic settle();
    #1;
    check_outputs();
  endtask

  task automatic advance();
    @(posedge p_clk);
    model_update();
    @(negedge p_clk);
  endtask

  task automatic idle_inputs();
    p_rst = 1'b0;
    p_INST_MemRead = 1'b0; p_INST_MemAddress = '0;
    p_DATA_MemRead = 1'b0; p_DATA_MemWrite = 4'b0000;
    p_DATA_MemAddress = '0; p_DATA_MemDataOut = '0;
    p_MEM_Ready = 1'b0; p_MEM_ReadData = {$urandom, $urandom};
  endtask

  function automatic logic [W-1:0] rand64();
    return {$urandom, $urandom};
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  int exp_seq[10] = '{2, 2, 2, 2, 1, 2, 2, 2, 2, 1};
  int grants[$];

  initial begin
    m_owner = 0; m_addr = '0; m_wdata = '0; m_read = 1'b0; m_write = 4'b0000; m_streak = 0;
    idle_inputs();
    p_rst = 1'b1;
    @(negedge p_clk);
    advance();
    advance();
    p_rst = 1'b0;
    settle();
    check("rst_grant", W'(p_ARB_Grant), '0);
    check("rst_addr",  p_MEM_Address,   '0);
    check("rst_read",  W'(p_MEM_Read),  '0);
    check("rst_write", W'(p_MEM_Write), '0);
    advance();

    // Instruction-only fetch, Ready on the third strobe cycle.
    p_INST_MemRead = 1'b1; p_INST_MemAddress = 64'h100;
    settle(); check("i_wait_c0", W'(p_INST_MemWait), 1); check("i_read_c0", W'(p_MEM_Read), 0);
    advance();
    settle(); check("i_read_c1", W'(p_MEM_Read), 1); check("i_addr_c1", p_MEM_Address, 64'h100);
    check("i_grant_c1", W'(p_ARB_Grant), 1); check("i_wait_c1", W'(p_INST_MemWait), 1);
    advance();
    settle(); check("i_read_c2", W'(p_MEM_Read), 1); check("i_wait_c2", W'(p_INST_MemWait), 1);
    advance();
    p_MEM_Ready = 1'b1; p_MEM_ReadData = 64'h1122334455667788;
    settle(); check("i_read_c3", W'(p_MEM_Read), 1); check("i_wait_c3", W'(p_INST_MemWait), 0);
    check("i_rdata_c3", W'(p_INST_MemDataIn), 64'h55667788);
    advance();
    idle_inputs();
    settle(); check("i_read_c4", W'(p_MEM_Read), 0); check("i_grant_c4", W'(p_ARB_Grant), 0);
    advance();

    // Simultaneous store and fetch: data first, instruction next.
    p_DATA_MemAddress = 64'h2000; p_DATA_MemWrite = 4'hF; p_DATA_MemDataOut = 64'hDEADBEEFCAFEF00D;
    p_INST_MemRead = 1'b1; p_INST_MemAddress = 64'h40;
    settle(); advance();
    p_MEM_Ready = 1'b1;
    settle(); check("s_grant", W'(p_ARB_Grant), 2); check("s_write", W'(p_MEM_Write), 4'hF);
    check("s_read", W'(p_MEM_Read), 0); check("s_addr", p_MEM_Address, 64'h2000);
    check("s_wdata", p_MEM_WriteData, 64'hDEADBEEFCAFEF00D); check("s_iwait", W'(p_INST_MemWait), 1);
    advance();
    p_DATA_MemWrite = 4'h0; p_MEM_Ready = 1'b0;
    settle(); check("s_idle", W'(p_ARB_Grant), 0); advance();
    p_MEM_Ready = 1'b1;
    settle(); check("s_igrant", W'(p_ARB_Grant), 1); check("s_iaddr", p_MEM_Address, 64'h40);
    check("s_iwait_done", W'(p_INST_MemWait), 0);
    advance();
    idle_inputs();
    settle(); advance();

    // Starvation bound with both requests held and Ready always high.
    p_INST_MemRead = 1'b1; p_INST_MemAddress = 64'h80;
    p_DATA_MemRead = 1'b1; p_DATA_MemAddress = 64'h3000; p_MEM_Ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      settle();
      if (p_ARB_Grant != 2'b00) grants.push_back(int'(p_ARB_Grant));
      advance();
    end
    check("burst_count", W'(grants.size()), 10);
    for (int k = 0; k < 10 && k < grants.size(); k++) begin
      check($sformatf("burst_grant%0d", k), W'(grants[k]), W'(exp_seq[k]));
    end
    idle_inputs();
    settle(); advance();

    // Load and store strobes together: store wins.
    p_DATA_MemRead = 1'b1; p_DATA_MemWrite = 4'h3; p_DATA_MemAddress = 64'h500;
    settle(); advance();
    p_MEM_Ready = 1'b1;
    settle(); check("ls_write", W'(p_MEM_Write), 4'h3); check("ls_read", W'(p_MEM_Read), 0);
    advance();
    idle_inputs();
    settle(); advance();

    // Reset in the middle of a data access.
    p_DATA_MemRead = 1'b1; p_DATA_MemAddress = 64'h600; p_DATA_MemDataOut = 64'hABCD;
    settle(); advance();
    settle(); check("r_grant_acc", W'(p_ARB_Grant), 2); advance();
    p_rst = 1'b1;
    settle(); advance();
    p_rst = 1'b0; p_MEM_Ready = 1'b1;
    settle(); check("r_grant", W'(p_ARB_Grant), 0); check("r_addr", p_MEM_Address, '0);
    check("r_wdata", p_MEM_WriteData, '0); check("r_read", W'(p_MEM_Read), 0);
    check("r_write", W'(p_MEM_Write), 0); check("r_dwait", W'(p_DATA_MemWait), 1);
    advance();
    p_DATA_MemRead = 1'b0;
    settle(); advance();
    idle_inputs();
    settle(); advance();

    // Requester withdraws mid-access.
    p_INST_MemRead = 1'b1; p_INST_MemAddress = 64'h700;
    settle(); advance();
    p_INST_MemRead = 1'b0; p_INST_MemAddress = 64'h900;
    settle(); check("d_addr1", p_MEM_Address, 64'h700); check("d_read1", W'(p_MEM_Read), 1);
    check("d_iwait1", W'(p_INST_MemWait), 0);
    advance();
    settle(); check("d_addr2", p_MEM_Address, 64'h700); advance();
    p_MEM_Ready = 1'b1;
    settle(); advance();
    p_MEM_Ready = 1'b0;
    settle(); check("d_nogrant", W'(p_ARB_Grant), 0); advance();
    settle(); check("d_nogrant2", W'(p_ARB_Grant), 0); advance();

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      p_rst             = ($urandom_range(0, 59) == 0);
      p_INST_MemRead    = 1'($urandom_range(0, 1));
      p_INST_MemAddress = rand64();
      p_DATA_MemRead    = 1'($urandom_range(0, 1));
      p_DATA_MemWrite   = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
      p_DATA_MemAddress = rand64();
      p_DATA_MemDataOut = rand64();
      p_MEM_Ready       = 1'($urandom_range(0, 2) != 0);
      p_MEM_ReadData    = rand64();
      settle();
      advance();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter WIDTH, default 64, data and address width of data port and memory.
REQ-002 Parameter MAX_DATA_BURST, default 4, maximum consecutive data grants while an instruction request is pending.
REQ-003 p_clk  in  1  single clock; all state updates on rising edge.
REQ-004 p_rst  in  1  synchronous reset, active-high.
REQ-005 p_INST_MemAddress  in  WIDTH  instruction fetch address.
REQ-006 p_INST_MemRead  in  1  instruction read request; held until wait deasserted.
REQ-007 p_INST_MemDataIn  out  32  instruction data, = p_MEM_ReadData[31:0].
REQ-008 p_INST_MemWait  out  1  instruction port stall.
REQ-009 p_DATA_MemAddress  in  WIDTH  data access address.
REQ-010 p_DATA_MemDataOut  in  WIDTH  store data.
REQ-011 p_DATA_MemRead  in  1  load request.
REQ-012 p_DATA_MemWrite  in  4  store byte-lane enables; any bit set = store request.
REQ-013 p_DATA_MemDataIn  out  WIDTH  load data, = p_MEM_ReadData.
REQ-014 p_DATA_MemWait  out  1  data port stall.
REQ-015 p_MEM_Address / p_MEM_WriteData  out  WIDTH each  registered memory address / store data.
REQ-016 p_MEM_Read  out  1, p_MEM_Write  out  4  registered memory strobes.
REQ-017 p_MEM_ReadData  in  WIDTH, p_MEM_Ready  in  1  memory response; Ready marks access completion.
REQ-018 p_ARB_Grant  out  2  current owner: 00 none, 01 instruction, 10 data.

Function
REQ-019 States IDLE, INST_ACC, DATA_ACC; arbitration occurs only in IDLE.
REQ-020 inst_req = p_INST_MemRead; data_req = p_DATA_MemRead OR (p_DATA_MemWrite != 0).
REQ-021 IDLE, data_req only -> DATA_ACC; inst_req only -> INST_ACC; neither -> stay IDLE.
REQ-022 IDLE, both pending: data wins unless data_streak == MAX_DATA_BURST, then instruction wins.
REQ-023 On grant, requester address/store data/strobes are latched into the p_MEM_* registers; memory strobes are asserted from the following cycle until completion.
REQ-024 Data grant with nonzero p_DATA_MemWrite drives p_MEM_Write = that value, p_MEM_Read = 0 (store takes precedence over a simultaneous load strobe).
REQ-025 Instruction grant drives p_MEM_Read = 1, p_MEM_Write = 0.
REQ-026 In *_ACC, p_MEM_Ready = 1 is completion: strobes clear and state returns to IDLE at next edge; p_MEM_Ready is ignored in IDLE.
REQ-027 p_INST_MemWait = inst_req AND NOT (state == INST_ACC AND p_MEM_Ready), combinational; p_DATA_MemWait analogous with DATA_ACC.
REQ-028 Requester with no request sees wait = 0.
REQ-029 Minimum access: request at cycle 0, strobes cycle 1, Ready at cycle 1 gives wait low at cycle 1, IDLE at cycle 2; throughput one access per 2 cycles minimum.
REQ-030 Requests changing or dropping during *_ACC do not alter the latched access; access completes and result is discarded.
REQ-031 data_streak (width clog2(MAX_DATA_BURST+1)): +1 on data grant with inst_req high, saturating at MAX_DATA_BURST; cleared on instruction grant, or at any IDLE cycle with inst_req low.
REQ-032 p_ARB_Grant reflects state: IDLE 00, INST_ACC 01, DATA_ACC 10.

Reset
REQ-033 p_rst = 1 at an edge: state IDLE, data_streak 0, p_MEM_Address/WriteData 0, p_MEM_Read 0, p_MEM_Write 0, p_ARB_Grant 00; takes priority over all other updates.
REQ-034 Reset during *_ACC abandons the access; strobes low from the cycle after the reset edge; later p_MEM_Ready ignored.

Verification
REQ-035 Inst only: address 0x100 read, Ready after 3 cycles -> p_MEM_Read high cycles 1-3, p_INST_MemWait high cycles 0-2, low cycle 3, DataIn = ReadData[31:0].
REQ-036 Simultaneous: data store 0x2000, Write=4'hF, data 0xDEADBEEFCAFEF00D, inst fetch 0x40 -> data granted first with p_MEM_Write=F, Read=0; instruction granted in next IDLE.
REQ-037 Starvation: data_req and inst_req held high continuously, MAX_DATA_BURST=4, Ready=1 every strobe cycle -> grant sequence D,D,D,D,I,D,D,D,D,I.
REQ-038 Load+store strobes together (Read=1, Write=4'h3) -> p_MEM_Write=3, p_MEM_Read=0.
REQ-039 Reset asserted in DATA_ACC before Ready -> all p_MEM_* outputs 0 and Grant 00 next cycle; Ready pulse afterward causes no wait change.
REQ-040 Requester drops request mid-access -> latched address/strobes unchanged until Ready; no further grant to that port.
